// File: rtl/int_to_fp27.sv
// Three-stage signed fixed-point to 27-bit float converter (sign, 8-bit biased exponent, 18-bit mantissa).
// Mantissa is truncated toward zero; zero and idle slots produce 27'h0.
module int_to_fp27 #(
    parameter int unsigned INT_WIDTH = 16,
    parameter int unsigned FRAC_BITS = 0
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_en,
    input  logic                 i_valid,
    input  logic [INT_WIDTH-1:0] i_int,
    output logic                 o_valid,
    output logic [26:0]          o_float
);

    localparam int unsigned POS_W  = $clog2(INT_WIDTH);
    localparam int unsigned MANT_W = 18;
    localparam int unsigned EXP_W  = 8;
    localparam int unsigned EXT_W  = INT_WIDTH + MANT_W;
    localparam int unsigned FLT_W  = 1 + EXP_W + MANT_W;

    // stage 1: sign and magnitude
    logic                 s1_valid_d, s1_valid_q;
    logic                 s1_sign_d,  s1_sign_q;
    logic [INT_WIDTH-1:0] s1_mag_d,   s1_mag_q;

    // stage 2: zero flag and leading-one position
    logic                 s2_valid_d, s2_valid_q;
    logic                 s2_sign_d,  s2_sign_q;
    logic                 s2_zero_d,  s2_zero_q;
    logic [POS_W-1:0]     s2_pos_d,   s2_pos_q;
    logic [INT_WIDTH-1:0] s2_mag_d,   s2_mag_q;

    // stage 3: packed result
    logic                 out_valid_d, out_valid_q;
    logic [FLT_W-1:0]     out_float_d, out_float_q;

    logic [POS_W-1:0]     shamt;
    logic [INT_WIDTH-1:0] norm;
    logic [EXT_W-1:0]     ext;
    logic [MANT_W-1:0]    mant;
    logic [EXP_W-1:0]     expo;

    // Idle slots carry a zero magnitude so o_float reads 0 whenever o_valid is low.
    // The most-negative input negates to 2^(INT_WIDTH-1), which fits unsigned.
    always_comb begin
        s1_valid_d = i_valid;
        s1_sign_d  = 1'b0;
        s1_mag_d   = '0;
        if (i_valid) begin
            s1_sign_d = i_int[INT_WIDTH-1];
            s1_mag_d  = i_int[INT_WIDTH-1] ? (~i_int + INT_WIDTH'(1)) : i_int;
        end
    end

    always_comb begin
        s2_valid_d = s1_valid_q;
        s2_sign_d  = s1_sign_q;
        s2_mag_d   = s1_mag_q;
        s2_zero_d  = (s1_mag_q == '0);
        s2_pos_d   = '0;
        for (int unsigned i = 0; i < INT_WIDTH; i++) begin
            if (s1_mag_q[i]) begin
                s2_pos_d = POS_W'(i);
            end
        end
    end

    // Leading one is shifted to the MSB; the 18 bits beneath it (zero-padded) form the mantissa.
    always_comb begin
        shamt       = POS_W'(INT_WIDTH - 1) - s2_pos_q;
        norm        = s2_mag_q << shamt;
        ext         = {norm, MANT_W'(0)};
        mant        = MANT_W'(ext >> (INT_WIDTH - 1));
        expo        = EXP_W'(127) + EXP_W'(s2_pos_q) - EXP_W'(FRAC_BITS);
        out_valid_d = s2_valid_q;
        out_float_d = s2_zero_q ? '0 : {s2_sign_q, expo, mant};
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            s1_valid_q  <= 1'b0;
            s1_sign_q   <= 1'b0;
            s1_mag_q    <= '0;
            s2_valid_q  <= 1'b0;
            s2_sign_q   <= 1'b0;
            s2_zero_q   <= 1'b0;
            s2_pos_q    <= '0;
            s2_mag_q    <= '0;
            out_valid_q <= 1'b0;
            out_float_q <= '0;
        end else if (i_en) begin
            s1_valid_q  <= s1_valid_d;
            s1_sign_q   <= s1_sign_d;
            s1_mag_q    <= s1_mag_d;
            s2_valid_q  <= s2_valid_d;
            s2_sign_q   <= s2_sign_d;
            s2_zero_q   <= s2_zero_d;
            s2_pos_q    <= s2_pos_d;
            s2_mag_q    <= s2_mag_d;
            out_valid_q <= out_valid_d;
            out_float_q <= out_float_d;
        end
    end

    assign o_valid = out_valid_q;
    assign o_float = out_float_q;

endmodule

// File: tb/tb_int_to_fp27.sv
// Bench for int_to_fp27: three parameterisations driven in lockstep, checked each cycle
// against an arithmetic conversion model delayed by three enabled edges.
module tb_int_to_fp27;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en  = 1'b0;
    logic        vld = 1'b0;
    logic [15:0] int0 = '0;
    logic [23:0] int1 = '0;
    logic [15:0] int2 = '0;
    logic        ov0, ov1, ov2;
    logic [26:0] of0, of1, of2;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    int_to_fp27 #(.INT_WIDTH(16), .FRAC_BITS(0)) dut0 (
        .i_clk(clk), .i_reset(rst), .i_en(en), .i_valid(vld), .i_int(int0),
        .o_valid(ov0), .o_float(of0));
    int_to_fp27 #(.INT_WIDTH(24), .FRAC_BITS(0)) dut1 (
        .i_clk(clk), .i_reset(rst), .i_en(en), .i_valid(vld), .i_int(int1),
        .o_valid(ov1), .o_float(of1));
    int_to_fp27 #(.INT_WIDTH(16), .FRAC_BITS(8)) dut2 (
        .i_clk(clk), .i_reset(rst), .i_en(en), .i_valid(vld), .i_int(int2),
        .o_valid(ov2), .o_float(of2));

    task automatic chk(input string name, input logic [26:0] act, input logic [26:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h, want %h", name, $time, act, exp);
        end
    endtask

    // value = v / 2^frac; float = (-1)^s * 1.m * 2^(e-127), m truncated to 18 bits
    function automatic logic [26:0] conv(input longint v, input int frac);
        longint mag;
        longint rem;
        int     p;
        int     e;
        logic [17:0] m;
        if (v == 0) return 27'h0;
        mag = (v < 0) ? -v : v;
        p = 0;
        while ((longint'(1) << (p + 1)) <= mag) p++;
        rem = mag - (longint'(1) << p);
        if (p >= 18) m = 18'(rem >> (p - 18));
        else         m = 18'(rem << (18 - p));
        e = 127 + p - frac;
        return {(v < 0), 8'(e), m};
    endfunction

    typedef struct {
        logic        v;
        logic [26:0] f0;
        logic [26:0] f1;
        logic [26:0] f2;
    } exp_t;

    exp_t q[$];

    // Expected result of each enabled edge; the output shows the one from two edges earlier.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
        end else if (en) begin
            exp_t e;
            e.v  = vld;
            e.f0 = conv(longint'($signed(int0)), 0);
            e.f1 = conv(longint'($signed(int1)), 0);
            e.f2 = conv(longint'($signed(int2)), 8);
            q.push_back(e);
            if (q.size() > 3) void'(q.pop_front());
        end
    end

    always @(negedge clk) begin
        exp_t e;
        e = '{v: 1'b0, f0: 27'h0, f1: 27'h0, f2: 27'h0};
        if (q.size() == 3) e = q[0];
        chk("valid0", 27'(ov0), 27'(e.v));
        chk("valid1", 27'(ov1), 27'(e.v));
        chk("valid2", 27'(ov2), 27'(e.v));
        if (e.v) begin
            chk("float0", of0, e.f0);
            chk("float1", of1, e.f1);
            chk("float2", of2, e.f2);
        end
        if (rst) begin
            chk("rst_float0", of0, 27'h0);
            chk("rst_float1", of1, 27'h0);
            chk("rst_float2", of2, 27'h0);
        end
    end

    task automatic drive(input logic e_in, input logic v_in, input int a, input int b, input int c);
        en   = e_in;
        vld  = v_in;
        int0 = 16'(a);
        int1 = 24'(b);
        int2 = 16'(c);
        @(negedge clk);
    endtask

    initial begin
        // model pins, hand-derived from sign/exponent/mantissa fields
        chk("pin_1",      conv(1, 0),       {1'b0, 8'd127, 18'h00000});
        chk("pin_640",    conv(640, 0),     {1'b0, 8'd136, 18'h10000});
        chk("pin_min16",  conv(-32768, 0),  {1'b1, 8'd142, 18'h00000});
        chk("pin_zero",   conv(0, 0),       27'h0);
        chk("pin_trunc",  conv(524289, 0),  {1'b0, 8'd146, 18'h00000});
        chk("pin_m3",     conv(-3, 0),      {1'b1, 8'd128, 18'h20000});
        chk("pin_1p5",    conv(384, 8),     {1'b0, 8'd127, 18'h20000});
        chk("pin_lsb_f8", conv(1, 8),       {1'b0, 8'd119, 18'h00000});
        chk("pin_5",      conv(5, 0),       {1'b0, 8'd129, 18'h10000});
        chk("pin_7",      conv(7, 0),       {1'b0, 8'd129, 18'h30000});

        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // back-to-back stream with literal expectations
        drive(1, 1, 1,      524289, 'h0180);
        drive(1, 1, 640,    -3,     'h0001);
        drive(1, 1, -32768, 0,      0);
        chk("lit_v_a",  27'(ov0), 27'h1);
        chk("lit_f0_a", of0, 27'h1FC0000);
        chk("lit_f1_a", of1, 27'h2480000);
        chk("lit_f2_a", of2, 27'h1FE0000);
        drive(1, 1, 0, 0, 0);
        chk("lit_f0_b", of0, 27'h2210000);
        chk("lit_f1_b", of1, 27'h6020000);
        chk("lit_f2_b", of2, 27'h1DC0000);
        drive(1, 0, 0, 0, 0);
        chk("lit_f0_c", of0, 27'h6380000);
        drive(1, 0, 0, 0, 0);
        chk("lit_v_d",  27'(ov0), 27'h1);
        chk("lit_f0_d", of0, 27'h0000000);
        drive(1, 0, 0, 0, 0);

        // enable stall after the second sample
        drive(1, 1, 1, 1, 1);
        drive(1, 1, 2, 2, 2);
        drive(0, 0, 77, 77, 77);
        drive(0, 0, 88, 88, 88);
        drive(1, 1, 3, 3, 3);
        chk("stall_f0", of0, 27'h1FC0000);
        repeat (3) drive(1, 0, 0, 0, 0);

        // valid gaps
        drive(1, 1, 5, 5, 5);
        drive(1, 0, 99, 99, 99);
        drive(1, 1, 7, 7, 7);
        chk("gap_f0_5", of0, 27'h2050000);
        drive(1, 0, 0, 0, 0);
        chk("gap_v_x",  27'(ov0), 27'h0);
        drive(1, 0, 0, 0, 0);
        chk("gap_f0_7", of0, 27'h2070000);
        drive(1, 0, 0, 0, 0);

        // asynchronous reset with samples in flight
        drive(1, 1, 11, 12, 13);
        drive(1, 1, -11, -12, -13);
        en = 1'b1; vld = 1'b1; int0 = 16'd100; int1 = 24'd100; int2 = 16'd100;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_v0", 27'(ov0), 27'h0);
        chk("async_f0", of0, 27'h0);
        chk("async_f1", of1, 27'h0);
        chk("async_f2", of2, 27'h0);
        @(negedge clk);
        vld = 1'b0;
        rst = 1'b0;
        repeat (10) @(negedge clk);
        chk("post_rst_f0", of0, 27'h0);

        // randomized stream with occasional stalls, gaps and boundary values
        for (int i = 0; i < 3000; i++) begin
            int r;
            int a, b, c;
            r = int'($urandom_range(0, 9));
            a = int'($urandom); b = int'($urandom); c = int'($urandom);
            case (r)
                0: begin a = -32768; b = -8388608; c = -32768; end
                1: begin a = 32767;  b = 8388607;  c = 32767;  end
                2: begin a = 0;      b = 0;        c = 0;      end
                3: begin a = int'($urandom_range(0, 8)) - 4; b = a; c = a; end
                default: ;
            endcase
            drive(($urandom_range(0, 4) != 0), ($urandom_range(0, 9) < 7), a, b, c);
        end
        repeat (5) drive(1, 0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
